entrada_operandos: RTL
======================

# entrada_operandos

- Operand-entry front end for the 1-bit full-adder datapath.
- Takes one raw push-button and one raw value switch from the board and debounces the button.
- The user commits the operands n1, n2 and te one at a time, in that order.
- Presents the three operands as registered bits with a `valido` flag to the adder/display chain downstream.

## Interface

Parameters:
- `DEB_CYCLES`, default 50000: consecutive cycles the synchronized button must differ from its filtered level before the filtered level changes.
  - Legal range ≥ 2.
  - Benches use 4.

Ports:
- `clk` in 1: single system clock. All state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `btn` in 1: raw push-button, active-high, asynchronous to `clk`, bouncy.
- `sw` in 1: raw value switch, asynchronous to `clk`. Its level is the bit being committed.
- `n1` out 1: registered first operand.
- `n2` out 1: registered second operand.
- `te` out 1: registered carry-in.
- `valido` out 1: high while all three operands are committed and stable.
- `estado` out 2: current entry state, for status LEDs.
- `pulso` out 1: one-cycle press strobe (debug and verification visibility).

## Operation

Input path:
- `btn` and `sw` each pass through a two-flop synchronizer, giving `btn_s` and `sw_s`.

Debounce filter:
- Holds a filtered level `estavel` and a counter of width $clog2(DEB_CYCLES).
- Each cycle that `btn_s` != `estavel`, the counter increments.
- When the counter equals DEB_CYCLES-1 and the inputs still differ, `estavel` <= `btn_s` and the counter clears.
- Any cycle with `btn_s` == `estavel` clears the counter. A bounce therefore restarts the count.
- `pulso` = `estavel` & ~`estavel_q`, where `estavel_q` is `estavel` delayed one cycle.
- Release edges produce no strobe.

State machine:
- Encodings: ESPERA_N1 = 0, ESPERA_N2 = 1, ESPERA_TE = 2, PRONTO = 3. `estado` outputs the encoding directly.
- ESPERA_N1 + `pulso`: `n1` <= `sw_s`, go to ESPERA_N2.
- ESPERA_N2 + `pulso`: `n2` <= `sw_s`, go to ESPERA_TE.
- ESPERA_TE + `pulso`: `te` <= `sw_s`, `valido` <= 1, go to PRONTO.
- PRONTO + `pulso`: `valido` <= 0, `n1`/`n2`/`te` <= 0, go to ESPERA_N1. No capture happens on this press.
- With no `pulso`, every register holds its value.
- `n1`/`n2`/`te` change only on capture, or when clearing out of PRONTO. Downstream may read them combinationally.

Reset:
- `rst_n` low, including mid-debounce or mid-entry, forces immediately all of the following to 0:
  - synchronizer flops, counter, `estavel`, `estavel_q`
  - `n1`, `n2`, `te`, `valido`, `pulso`
  - `estado` = ESPERA_N1
- A button held through reset release produces one `pulso` after the full debounce latency. The first press is never lost.

## Timing

- Edge 0 is the first rising edge at which `btn` = 1 is sampled, with `btn` held high afterwards.
- Edge 1: `btn_s` = 1.
- Edges 2 through 1+DEB_CYCLES: counter counts. `estavel` rises at edge 1+DEB_CYCLES.
- `pulso` is high for exactly the one cycle after edge 1+DEB_CYCLES.
- Capture and state transition occur at edge 2+DEB_CYCLES.
- The captured value is `sw` as sampled at edge DEB_CYCLES. `sw` must be stable from edge DEB_CYCLES-2 onward to be captured deterministically.
- Minimum press spacing: the release must also debounce (DEB_CYCLES+2 cycles low) before the next press can strobe.
- No throughput beyond one operand per debounced press.

## Structure

- Package `entrada_pkg`:
  - state encodings ESPERA_N1, ESPERA_N2, ESPERA_TE, PRONTO as a 2-bit typedef
  - the debounce counter width function
- Sub-module `filtro_botao`:
  - parameter DEB_CYCLES
  - ports `clk`, `rst_n`, `btn`, `estavel`, `pulso`
  - contains the synchronizer, counter and edge detect
- The `sw` synchronizer and the state machine live in `entrada_operandos`.

## Test plan

All scenarios use DEB_CYCLES = 4.

1. **Reset values.** Assert `rst_n` low mid-simulation with arbitrary inputs → all outputs 0 and `estado` = 0 within the same cycle, asynchronously.
2. **Clean press latency.** Hold `sw` = 1 and raise `btn` cleanly at edge 0 → `pulso` high for one cycle after edge 5. At edge 6, `n1` = 1 and `estado` = 1. `valido` stays 0.
3. **Bounce rejection.** Toggle `btn` 1,0,1,0 on successive cycles, then hold it high → no `pulso` during the toggling. Exactly one `pulso` arrives 6 cycles after the last 0→1.
4. **Full entry.** Three debounced presses with `sw` = 1, 0, 1 → `n1` = 1, `n2` = 0, `te` = 1, `valido` = 1, `estado` = 3. A fourth press → all operands 0, `valido` = 0, `estado` = 0.
5. **Reset mid-operation.** Assert `rst_n` during ESPERA_TE while the counter is at 2 → outputs clear immediately. With `btn` still held after release, one `pulso` arrives DEB_CYCLES+2 edges later and captures into `n1`.
6. **No release strobe.** Debounced release of `btn` → no `pulso`, and `estado` is unchanged.

Source files
------------

// File: rtl/entrada_pkg.sv
// Shared types for the operand-entry front end: entry-state encoding and the
// debounce counter width helper.
package entrada_pkg;

  typedef enum logic [1:0] {
    ESPERA_N1 = 2'd0,
    ESPERA_N2 = 2'd1,
    ESPERA_TE = 2'd2,
    PRONTO    = 2'd3
  } estado_t;

  function automatic int unsigned largura_cnt(input int unsigned ciclos);
    int unsigned w;
    w = $clog2(ciclos);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/entrada_operandos_if.sv
// Board-side bundle of the operand-entry block: raw inputs in, committed
// operands and status out.
interface entrada_operandos_if;
  logic       btn;
  logic       sw;
  logic       n1;
  logic       n2;
  logic       te;
  logic       valido;
  logic [1:0] estado;
  logic       pulso;

  modport master (
    output btn, sw,
    input  n1, n2, te, valido, estado, pulso
  );

  modport slave (
    input  btn, sw,
    output n1, n2, te, valido, estado, pulso
  );
endinterface

// File: rtl/filtro_botao.sv
// Push-button synchronizer, counting debounce filter and rising-edge strobe.
module filtro_botao
  import entrada_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic estavel,
  output logic pulso
);

  localparam int unsigned     CW      = largura_cnt(DEB_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  logic [CW-1:0] cnt;
  logic          estavel_q;

  assign btn_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt       <= '0;
      estavel   <= 1'b0;
      estavel_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn};
      estavel_q <= estavel;
      // Any agreeing cycle restarts the count, so a bounce never accumulates.
      if (btn_s != estavel) begin
        if (cnt == CNT_MAX) begin
          estavel <= btn_s;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulso = estavel & ~estavel_q;

endmodule

// File: rtl/entrada_operandos.sv
// Operand-entry front end: commits n1, n2 and te from the value switch on
// successive debounced presses and flags when all three are held.
module entrada_operandos
  import entrada_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  entrada_operandos_if.slave   bus
);

  logic       sw_q1;
  logic       sw_s;
  logic       estavel;
  logic       pulso;
  estado_t    st;
  logic       n1_q;
  logic       n2_q;
  logic       te_q;
  logic       valido_q;

  filtro_botao #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_filtro (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (bus.btn),
    .estavel (estavel),
    .pulso   (pulso)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q1 <= 1'b0;
      sw_s  <= 1'b0;
    end else begin
      sw_q1 <= bus.sw;
      sw_s  <= sw_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ESPERA_N1;
      n1_q     <= 1'b0;
      n2_q     <= 1'b0;
      te_q     <= 1'b0;
      valido_q <= 1'b0;
    end else if (pulso) begin
      unique case (st)
        ESPERA_N1: begin
          n1_q <= sw_s;
          st   <= ESPERA_N2;
        end
        ESPERA_N2: begin
          n2_q <= sw_s;
          st   <= ESPERA_TE;
        end
        ESPERA_TE: begin
          te_q     <= sw_s;
          valido_q <= 1'b1;
          st       <= PRONTO;
        end
        PRONTO: begin
          n1_q     <= 1'b0;
          n2_q     <= 1'b0;
          te_q     <= 1'b0;
          valido_q <= 1'b0;
          st       <= ESPERA_N1;
        end
        default: st <= ESPERA_N1;
      endcase
    end
  end

  assign bus.n1     = n1_q;
  assign bus.n2     = n2_q;
  assign bus.te     = te_q;
  assign bus.valido = valido_q;
  assign bus.estado = st;
  assign bus.pulso  = pulso;

endmodule
